// File: rtl/axis_arb_pkg.sv
// rtl/axis_arb_pkg.sv - shared types, defaults and round-robin pick for the AXI-Stream arbiter
package axis_arb_pkg;

    localparam int AXIS_DATA_WIDTH_DEF = 24;
    localparam int NUM_SRC_DEF         = 2;
    localparam int MAX_SRC             = 4;
    localparam int MAX_ID_W            = 2;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_e;

    // First requester strictly after last, wrapping at num_src; returns last when nobody requests.
    function automatic logic [MAX_ID_W-1:0] rr_pick(
        input logic [MAX_SRC-1:0]  req,
        input logic [MAX_ID_W-1:0] last,
        input int                  num_src
    );
        logic [MAX_ID_W-1:0] pick;
        logic [MAX_ID_W-1:0] idx;
        logic                found;
        int                  cand;
        pick  = last;
        found = 1'b0;
        for (int k = 1; k <= MAX_SRC; k++) begin
            cand = int'(last) + k;
            if (cand >= num_src) begin
                cand = cand - num_src;
            end
            idx = cand[MAX_ID_W-1:0];
            if (k <= num_src && !found && req[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/axis_skid_buffer.sv
// rtl/axis_skid_buffer.sv - two-entry registered skid buffer for an AXI-Stream payload
module axis_skid_buffer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             s_tvalid,
    output logic             s_tready,
    input  logic [WIDTH-1:0] s_tdata,
    output logic             m_tvalid,
    input  logic             m_tready,
    output logic [WIDTH-1:0] m_tdata
);

    logic [WIDTH-1:0] head_q, head_d;
    logic [WIDTH-1:0] tail_q, tail_d;
    logic [1:0]       count_q, count_d;
    logic             push;
    logic             pop;

    // Ready depends only on registered occupancy, so no path runs from m_tready to s_tready.
    assign s_tready = (count_q != 2'd2);
    assign m_tvalid = (count_q != 2'd0);
    assign m_tdata  = head_q;
    assign push     = s_tvalid && s_tready;
    assign pop      = m_tvalid && m_tready;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        case (count_q)
            2'd0: begin
                if (push) begin
                    head_d  = s_tdata;
                    count_d = 2'd1;
                end
            end
            2'd1: begin
                if (push && pop) begin
                    head_d = s_tdata;
                end else if (push) begin
                    tail_d  = s_tdata;
                    count_d = 2'd2;
                end else if (pop) begin
                    count_d = 2'd0;
                end
            end
            default: begin
                if (pop) begin
                    head_d  = tail_q;
                    count_d = 2'd1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= 2'd0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/axis_rr_arbiter.sv
// rtl/axis_rr_arbiter.sv - packet-granular round-robin arbiter onto one AXI-Stream output
module axis_rr_arbiter
    import axis_arb_pkg::*;
#(
    parameter int  AXIS_DATA_WIDTH = AXIS_DATA_WIDTH_DEF,
    parameter int  NUM_SRC         = NUM_SRC_DEF,
    localparam int STRB_W          = AXIS_DATA_WIDTH / 8,
    localparam int ID_W            = $clog2(NUM_SRC)
) (
    input  logic                          aclk,
    input  logic                          arstn,
    input  logic [NUM_SRC-1:0]            s_axis_tvalid,
    output logic [NUM_SRC-1:0]            s_axis_tready,
    input  logic [NUM_SRC*AXIS_DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [NUM_SRC*STRB_W-1:0]     s_axis_tkeep,
    input  logic [NUM_SRC-1:0]            s_axis_tlast,
    input  logic [NUM_SRC-1:0]            s_axis_tuser,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic [AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
    output logic [STRB_W-1:0]             m_axis_tkeep,
    output logic                          m_axis_tlast,
    output logic                          m_axis_tuser,
    output logic [ID_W-1:0]               m_axis_tid,
    output logic                          busy,
    output logic [ID_W-1:0]               grant_id
);

    localparam int PAYLOAD_W = ID_W + 2 + STRB_W + AXIS_DATA_WIDTH;

    arb_state_e           state_q, state_d;
    logic [ID_W-1:0]      grant_q, grant_d;
    logic [ID_W-1:0]      last_grant_q, last_grant_d;

    logic                       sel_tvalid;
    logic                       sel_tlast;
    logic                       sel_tuser;
    logic [AXIS_DATA_WIDTH-1:0] sel_tdata;
    logic [STRB_W-1:0]          sel_tkeep;
    logic                       beat_acc;
    logic                       skid_s_tready;
    logic [PAYLOAD_W-1:0]       skid_m_tdata;

    always_comb begin
        sel_tvalid = 1'b0;
        sel_tlast  = 1'b0;
        sel_tuser  = 1'b0;
        sel_tdata  = '0;
        sel_tkeep  = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (grant_q == ID_W'(i)) begin
                sel_tvalid = s_axis_tvalid[i];
                sel_tlast  = s_axis_tlast[i];
                sel_tuser  = s_axis_tuser[i];
                sel_tdata  = s_axis_tdata[i*AXIS_DATA_WIDTH +: AXIS_DATA_WIDTH];
                sel_tkeep  = s_axis_tkeep[i*STRB_W +: STRB_W];
            end
        end
    end

    assign beat_acc = busy && sel_tvalid && skid_s_tready;

    always_ff @(posedge aclk or negedge arstn) begin
        if (!arstn) begin
            state_q      <= ARB_IDLE;
            grant_q      <= '0;
            last_grant_q <= ID_W'(NUM_SRC - 1);
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
        end
    end

    // The grant is only updated in IDLE; last_grant only moves when a packet ends.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        case (state_q)
            ARB_IDLE: begin
                if (|s_axis_tvalid) begin
                    grant_d = ID_W'(rr_pick(MAX_SRC'(s_axis_tvalid), MAX_ID_W'(last_grant_q), NUM_SRC));
                    state_d = ARB_BUSY;
                end
            end
            ARB_BUSY: begin
                if (beat_acc && sel_tlast) begin
                    last_grant_d = grant_q;
                    state_d      = ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_comb begin
        busy          = (state_q == ARB_BUSY);
        s_axis_tready = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            s_axis_tready[i] = busy && (grant_q == ID_W'(i)) && skid_s_tready;
        end
    end

    assign grant_id = grant_q;

    axis_skid_buffer #(
        .WIDTH(PAYLOAD_W)
    ) u_skid (
        .clk      (aclk),
        .rst_n    (arstn),
        .s_tvalid (busy && sel_tvalid),
        .s_tready (skid_s_tready),
        .s_tdata  ({grant_q, sel_tuser, sel_tlast, sel_tkeep, sel_tdata}),
        .m_tvalid (m_axis_tvalid),
        .m_tready (m_axis_tready),
        .m_tdata  (skid_m_tdata)
    );

    assign {m_axis_tid, m_axis_tuser, m_axis_tlast, m_axis_tkeep, m_axis_tdata} = skid_m_tdata;

endmodule

// File: tb/tb_axis_rr_arbiter.sv
// tb/tb_axis_rr_arbiter.sv - randomized self-checking bench for axis_rr_arbiter
module tb_axis_rr_arbiter;

    localparam int W  = 24;
    localparam int NS = 3;
    localparam int SW = W / 8;
    localparam int IW = 2;
    localparam int PW = IW + 2 + SW + W;

    typedef struct packed {
        logic [W-1:0]  data;
        logic [SW-1:0] keep;
        logic          last;
        logic          user;
    } beat_t;

    logic            aclk = 1'b0;
    logic            arstn;
    logic [NS-1:0]   s_axis_tvalid;
    logic [NS-1:0]   s_axis_tready;
    logic [NS*W-1:0] s_axis_tdata;
    logic [NS*SW-1:0] s_axis_tkeep;
    logic [NS-1:0]   s_axis_tlast;
    logic [NS-1:0]   s_axis_tuser;
    logic            m_axis_tvalid;
    logic            m_axis_tready;
    logic [W-1:0]    m_axis_tdata;
    logic [SW-1:0]   m_axis_tkeep;
    logic            m_axis_tlast;
    logic            m_axis_tuser;
    logic [IW-1:0]   m_axis_tid;
    logic            busy;
    logic [IW-1:0]   grant_id;

    axis_rr_arbiter #(
        .AXIS_DATA_WIDTH(W),
        .NUM_SRC        (NS)
    ) dut (
        .aclk          (aclk),
        .arstn         (arstn),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tkeep  (s_axis_tkeep),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tuser  (s_axis_tuser),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tuser  (m_axis_tuser),
        .m_axis_tid    (m_axis_tid),
        .busy          (busy),
        .grant_id      (grant_id)
    );

    always #5 aclk = ~aclk;

    int n_checks = 0;
    int n_errors = 0;

    beat_t        src_q[NS][$];
    beat_t        exp_q[NS][$];
    int           order_q[$];
    int           pkt_log[$];
    logic [W-1:0] data_log[$];

    int ready_pct = 100;
    int gap_pct   = 0;
    int mdl_busy  = 0;
    int mdl_grant = 0;
    int mdl_last  = NS - 1;
    int in_flight = 0;
    int out_mid   = 0;
    int out_tid   = 0;
    int acc_total = 0;
    int busy_cnt  = 0;
    logic [NS-1:0] hs_prev = '0;
    logic          prev_stall = 1'b0;
    logic [PW-1:0] prev_payload = '0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic bit bit_of(input logic [NS-1:0] v, input int i);
        return ((v >> i) & NS'(1)) != '0;
    endfunction

    // Next owner: first requester after the previous owner, wrapping around.
    function automatic int rr_model(input logic [NS-1:0] req, input int last);
        int c;
        for (int k = 1; k <= NS; k++) begin
            c = (last + k) % NS;
            if (bit_of(req, c)) return c;
        end
        return last;
    endfunction

    function automatic beat_t mk(input logic [W-1:0] d, input logic [SW-1:0] k,
                                 input logic l, input logic u);
        beat_t b;
        b.data = d;
        b.keep = k;
        b.last = l;
        b.user = u;
        return b;
    endfunction

    task automatic add_beat(input int s, input beat_t b);
        src_q[s].push_back(b);
        exp_q[s].push_back(b);
    endtask

    task automatic model_clear();
        for (int i = 0; i < NS; i++) begin
            src_q[i].delete();
            exp_q[i].delete();
        end
        order_q.delete();
        mdl_busy   = 0;
        mdl_last   = NS - 1;
        in_flight  = 0;
        out_mid    = 0;
        prev_stall = 1'b0;
        hs_prev    = '0;
    endtask

    task automatic observe();
        logic [NS-1:0] vmask;
        logic [NS-1:0] hs;
        logic [NS-1:0] onehot;
        logic [NS-1:0] exp_rdy;
        logic [PW-1:0] payload;
        beat_t         got;
        beat_t         want;
        int            tid;
        vmask = s_axis_tvalid;
        hs    = vmask & s_axis_tready;
        chk("m_tvalid", 64'(m_axis_tvalid), 64'(in_flight != 0));
        if (mdl_busy == 0) begin
            chk("idle_ready", 64'(s_axis_tready), 64'(0));
            chk("idle_busy", 64'(busy), 64'(0));
            if (vmask != '0) begin
                mdl_grant = rr_model(vmask, mdl_last);
                mdl_busy  = 1;
                order_q.push_back(mdl_grant);
            end
        end else begin
            onehot  = NS'(1) << mdl_grant;
            exp_rdy = (in_flight < 2) ? onehot : '0;
            chk("busy", 64'(busy), 64'(1));
            chk("grant_id", 64'(grant_id), 64'(mdl_grant));
            chk("s_tready", 64'(s_axis_tready), 64'(exp_rdy));
            if ((hs & onehot) != '0 && bit_of(s_axis_tlast, mdl_grant)) begin
                mdl_last = mdl_grant;
                mdl_busy = 0;
            end
        end
        for (int i = 0; i < NS; i++) begin
            if (bit_of(hs, i)) begin
                in_flight++;
                acc_total++;
            end
        end
        if (m_axis_tvalid && m_axis_tready) begin
            in_flight--;
            tid = int'(m_axis_tid);
            got = {m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser};
            if (out_mid == 0) begin
                chk("pkt_order_avail", 64'(order_q.size() != 0), 64'(1));
                if (order_q.size() != 0) chk("pkt_tid", 64'(tid), 64'(order_q.pop_front()));
                pkt_log.push_back(tid);
            end else begin
                chk("pkt_contig", 64'(tid), 64'(out_tid));
            end
            out_tid = tid;
            out_mid = m_axis_tlast ? 0 : 1;
            data_log.push_back(m_axis_tdata);
            chk("beat_avail", 64'(tid < NS && exp_q[tid % NS].size() != 0), 64'(1));
            if (tid < NS && exp_q[tid].size() != 0) begin
                want = exp_q[tid].pop_front();
                chk("beat", 64'(got), 64'(want));
            end
        end
        chk("in_flight", 64'(in_flight <= 2), 64'(1));
        payload = {m_axis_tid, m_axis_tuser, m_axis_tlast, m_axis_tkeep, m_axis_tdata};
        if (prev_stall) chk("stall_hold", 64'(payload), 64'(prev_payload));
        prev_stall   = m_axis_tvalid && !m_axis_tready;
        prev_payload = payload;
        if (busy) busy_cnt++;
        hs_prev = hs;
    endtask

    task automatic drive();
        beat_t b;
        for (int i = 0; i < NS; i++) begin
            if (bit_of(hs_prev, i) && src_q[i].size() > 0) void'(src_q[i].pop_front());
            if (src_q[i].size() > 0 && $urandom_range(99) >= gap_pct) begin
                b = src_q[i][0];
                s_axis_tvalid[i]         = 1'b1;
                s_axis_tdata[i*W +: W]   = b.data;
                s_axis_tkeep[i*SW +: SW] = b.keep;
                s_axis_tlast[i]          = b.last;
                s_axis_tuser[i]          = b.user;
            end else begin
                s_axis_tvalid[i] = 1'b0;
            end
        end
        hs_prev       = '0;
        m_axis_tready = ($urandom_range(99) < ready_pct);
    endtask

    initial begin
        s_axis_tvalid = '0;
        s_axis_tdata  = '0;
        s_axis_tkeep  = '0;
        s_axis_tlast  = '0;
        s_axis_tuser  = '0;
        m_axis_tready = 1'b0;
        forever begin
            @(negedge aclk);
            if (arstn) begin
                observe();
            end else begin
                hs_prev    = '0;
                prev_stall = 1'b0;
            end
            @(posedge aclk);
            #1;
            drive();
        end
    end

    task automatic step();
        @(posedge aclk);
        #2;
    endtask

    function automatic bit all_empty();
        for (int i = 0; i < NS; i++) begin
            if (src_q[i].size() != 0 || exp_q[i].size() != 0) return 1'b0;
        end
        return order_q.size() == 0 && in_flight == 0;
    endfunction

    task automatic drain(input int max_cyc);
        int n;
        n = 0;
        while (!all_empty() && n < max_cyc) begin
            @(negedge aclk);
            n++;
        end
        chk("drain_timeout", 64'(n < max_cyc), 64'(1));
        step();
    endtask

    task automatic wait_accepts(input int cnt);
        int base;
        int n;
        base = acc_total;
        n    = 0;
        while (acc_total < base + cnt && n < 200) begin
            step();
            n++;
        end
        chk("accept_timeout", 64'(n < 200), 64'(1));
    endtask

    initial begin
        int n;
        int b0;
        arstn = 1'b0;
        repeat (3) step();
        chk("rst_m_tvalid", 64'(m_axis_tvalid), 64'(0));
        chk("rst_s_tready", 64'(s_axis_tready), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_grant_id", 64'(grant_id), 64'(0));
        chk("rst_payload", 64'({m_axis_tid, m_axis_tuser, m_axis_tlast, m_axis_tkeep, m_axis_tdata}), 64'(0));
        arstn = 1'b1;
        step();

        // Two simultaneous 4-beat packets: source 0 first, output 2 cycles after tvalid.
        pkt_log.delete();
        for (int b = 0; b < 4; b++) begin
            add_beat(0, mk(W'(24'h100 + b), 3'h7, b == 3, 1'b0));
            add_beat(1, mk(W'(24'h200 + b), 3'h7, b == 3, 1'b0));
        end
        n = 0;
        do begin
            @(negedge aclk);
            n++;
        end while (s_axis_tvalid == '0 && n < 20);
        chk("lat_valid_seen", 64'(n < 20), 64'(1));
        @(negedge aclk);
        chk("lat_cycle1", 64'(m_axis_tvalid), 64'(0));
        @(negedge aclk);
        chk("lat_cycle2", 64'(m_axis_tvalid), 64'(1));
        drain(200);
        chk("t1_npkt", 64'(pkt_log.size()), 64'(2));
        if (pkt_log.size() == 2) begin
            chk("t1_first", 64'(pkt_log[0]), 64'(0));
            chk("t1_second", 64'(pkt_log[1]), 64'(1));
        end

        // Continuous 3-beat packets from sources 0 and 1.
        pkt_log.delete();
        b0 = busy_cnt;
        for (int p = 0; p < 10; p++) begin
            for (int s = 0; s < 2; s++) begin
                for (int b = 0; b < 3; b++) begin
                    add_beat(s, mk(W'($urandom), 3'($urandom), b == 2, 1'($urandom)));
                end
            end
        end
        drain(500);
        chk("t2_npkt", 64'(pkt_log.size()), 64'(20));
        for (int i = 0; i < pkt_log.size(); i++) chk("t2_alt", 64'(pkt_log[i]), 64'(i % 2));
        chk("t2_busy_cycles", 64'(busy_cnt - b0), 64'(60));

        // 16 beats under 50% backpressure.
        ready_pct = 50;
        data_log.delete();
        for (int b = 0; b < 16; b++) add_beat(0, mk(W'(b), 3'h7, b == 15, 1'b0));
        drain(1000);
        chk("t3_nbeats", 64'(data_log.size()), 64'(16));
        for (int i = 0; i < data_log.size(); i++) chk("t3_data", 64'(data_log[i]), 64'(i));
        ready_pct = 100;

        // Source 2 alone, source 0 arrives mid-packet.
        pkt_log.delete();
        for (int b = 0; b < 6; b++) add_beat(2, mk(W'(24'h300 + b), 3'h7, b == 5, 1'b0));
        wait_accepts(2);
        for (int b = 0; b < 3; b++) add_beat(0, mk(W'(24'h400 + b), 3'h7, b == 2, 1'b0));
        drain(200);
        chk("t4_npkt", 64'(pkt_log.size()), 64'(2));
        if (pkt_log.size() == 2) begin
            chk("t4_first", 64'(pkt_log[0]), 64'(2));
            chk("t4_second", 64'(pkt_log[1]), 64'(0));
        end

        // Single-beat packets with tuser from source 1.
        pkt_log.delete();
        b0 = busy_cnt;
        for (int p = 0; p < 5; p++) add_beat(1, mk(W'($urandom), 3'h7, 1'b1, 1'b1));
        drain(200);
        chk("t5_npkt", 64'(pkt_log.size()), 64'(5));
        for (int i = 0; i < pkt_log.size(); i++) chk("t5_tid", 64'(pkt_log[i]), 64'(1));
        chk("t5_busy_cycles", 64'(busy_cnt - b0), 64'(5));

        // Reset during beat 3 of an 8-beat packet.
        for (int b = 0; b < 8; b++) add_beat(0, mk(W'(24'h500 + b), 3'h7, b == 7, 1'b0));
        wait_accepts(2);
        arstn = 1'b0;
        model_clear();
        @(negedge aclk);
        chk("t6_m_tvalid", 64'(m_axis_tvalid), 64'(0));
        chk("t6_s_tready", 64'(s_axis_tready), 64'(0));
        chk("t6_busy", 64'(busy), 64'(0));
        step();
        step();
        arstn = 1'b1;
        step();
        pkt_log.delete();
        for (int b = 0; b < 4; b++) add_beat(0, mk(W'(24'h600 + b), 3'h7, b == 3, 1'b0));
        drain(200);
        chk("t6_npkt", 64'(pkt_log.size()), 64'(1));
        if (pkt_log.size() == 1) chk("t6_tid", 64'(pkt_log[0]), 64'(0));

        // Random soak: all sources, random lengths, gaps and backpressure.
        ready_pct = 70;
        gap_pct   = 20;
        for (int p = 0; p < 40; p++) begin
            int s;
            int len;
            s   = int'($urandom_range(NS - 1));
            len = int'($urandom_range(5, 1));
            for (int b = 0; b < len; b++) begin
                add_beat(s, mk(W'($urandom), 3'($urandom), b == len - 1, 1'($urandom)));
            end
        end
        drain(4000);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
